// File: rtl/uart_rx_async.sv
// rtl/uart_rx_async.sv - 16x oversampled UART receiver; UART_RX_MAJORITY_VOTE_EN enables 3-sample voting
module uart_rx_async #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rx,
  input  logic       read_rx_byte,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [3:0]             samp_cnt;
  logic [2:0]             bit_cnt;
  logic [2:0]             last_bit;
  logic [7:0]             shift_reg;
  logic                   par_bad;
  logic                   stop_bit;
  logic                   load_pending;
  logic                   samp_bit;
  logic                   at_sp;
  logic                   end_of_bit;
  logic                   data_xor;

  // Metastability synchroniser; preset high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] SP = 4'd9;

  logic vote7;
  logic vote8;

  // Capture the line at ticks 7 and 8 so the decision at tick 9 can take a 2-of-3 vote
  always_ff @(posedge clk) begin
    if (reset) begin
      vote7 <= 1'b1;
      vote8 <= 1'b1;
    end else if (baud_clock) begin
      if (samp_cnt == 4'd7) vote7 <= rx_s;
      if (samp_cnt == 4'd8) vote8 <= rx_s;
    end
  end

  assign samp_bit = (vote7 & vote8) | (vote7 & rx_s) | (vote8 & rx_s);
`else
  localparam logic [3:0] SP = 4'd8;

  assign samp_bit = rx_s;
`endif

  assign at_sp      = (samp_cnt == SP);
  assign end_of_bit = (samp_cnt == 4'd15);
  assign last_bit   = bit8 ? 3'd7 : 3'd6;
  assign data_xor   = bit8 ? (^shift_reg) : (^shift_reg[6:0]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; every transition waits for a baud tick
  always_comb begin
    state_d = state_q;
    rx_idle = (state_q == S_IDLE);
    if (baud_clock) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) state_d = S_START;
        end
        S_START: begin
          if (at_sp && samp_bit) begin
            state_d = S_IDLE;
          end else if (end_of_bit) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (end_of_bit && (bit_cnt == last_bit)) begin
            state_d = parity_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (end_of_bit) state_d = S_STOP;
        end
        S_STOP: begin
          // Leave at the stop sample so a back-to-back start edge is not missed
          if (at_sp) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Tick/bit counters and the per-frame datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_cnt     <= 4'd0;
      bit_cnt      <= 3'd0;
      shift_reg    <= 8'd0;
      par_bad      <= 1'b0;
      stop_bit     <= 1'b1;
      load_pending <= 1'b0;
    end else begin
      load_pending <= 1'b0;
      if (baud_clock) begin
        if (state_q == S_IDLE) begin
          samp_cnt <= rx_s ? 4'd0 : 4'd1;
        end else if (state_d == S_IDLE) begin
          samp_cnt <= 4'd0;
        end else begin
          samp_cnt <= samp_cnt + 4'd1;
        end

        case (state_q)
          S_START: begin
            bit_cnt <= 3'd0;
            par_bad <= 1'b0;
          end
          S_DATA: begin
            if (at_sp) shift_reg[bit_cnt] <= samp_bit;
            if (end_of_bit && (bit_cnt != last_bit)) bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: begin
            if (at_sp) par_bad <= ((data_xor ^ samp_bit) != odd_n_even);
          end
          S_STOP: begin
            if (at_sp) begin
              stop_bit     <= samp_bit;
              load_pending <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Host-facing result registers: load a finished frame, or flag overflow if unread data would be lost
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte     <= 8'd0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (load_pending && (!rx_ready || read_rx_byte)) begin
        rx_byte     <= bit8 ? shift_reg : {1'b0, shift_reg[6:0]};
        rx_ready    <= 1'b1;
        parity_err  <= par_bad & parity_en;
        framing_err <= ~stop_bit;
      end else if (read_rx_byte) begin
        rx_ready <= 1'b0;
      end

      if (read_rx_byte) begin
        overflow <= 1'b0;
      end else if (load_pending && rx_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_async.md
Name: uart_rx_async

Overview:
- Asynchronous UART receiver for the CoreUARTapb datapath; pairs with the existing transmitter on the same 16x baud enable.
- Synchronises the serial input, detects and validates the start bit, and samples 7 or 8 data bits LSB-first, with optional parity and one stop bit.
- Presents the received byte with ready, parity, framing and overflow status to the APB register block.

Parameters:
- SYNC_STAGES, 2, number of flops in the rx input synchroniser (legal 2..3).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- baud_clock  input  1  one-clk-wide enable pulse at 16x the bit rate
- bit8  input  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  input  1  1 = parity bit expected after the data bits
- odd_n_even  input  1  1 = odd parity, 0 = even parity
- rx  input  1  serial line, idle high, asynchronous to clk
- read_rx_byte  input  1  one-cycle pulse that acknowledges rx_byte
- rx_byte  output  8  last received data; bit 7 = 0 in 7-bit mode
- rx_ready  output  1  rx_byte holds unread data
- parity_err  output  1  parity error on the last loaded frame
- framing_err  output  1  stop bit sampled low on the last loaded frame
- overflow  output  1  frame completed while rx_ready = 1
- rx_idle  output  1  FSM is in IDLE

Behaviour:
- Reset (sync, all on the clk edge):
  - rx_byte = 0; rx_ready, parity_err, framing_err, overflow = 0; rx_idle = 1.
  - FSM = IDLE; counters = 0; synchroniser flops preset to 1.
- rx passes through SYNC_STAGES flops to give rx_s. All FSM activity below advances only on clk edges where baud_clock = 1.
- Tick counter samp_cnt is 4 bits and wraps 15 -> 0. Sample point SP = 8 (single sample).
- IDLE:
  - samp_cnt = 0.
  - On a tick with rx_s = 0 -> START, samp_cnt = 1.
- START:
  - At SP, if the sampled value = 1 (false start) -> IDLE.
  - Otherwise continue; at samp_cnt = 15 -> DATA, bit_cnt = 0.
- DATA:
  - At SP, shift the sample into shift_reg at bit position bit_cnt.
  - At samp_cnt = 15, bit_cnt increments.
  - After the last bit (bit_cnt = 7 if bit8, 6 otherwise) -> PARITY if parity_en, else STOP.
- PARITY:
  - At SP, par_bad = (XOR of data bits ^ sample) != odd_n_even.
  - At samp_cnt = 15 -> STOP.
- STOP:
  - At SP -> IDLE immediately, so the next start edge is caught within the same bit time.
  - On the following clk, the frame result is loaded.
- Frame load:
  - If rx_ready = 0, or read_rx_byte is asserted in the same cycle:
    - rx_byte = shift_reg, upper bit masked in 7-bit mode.
    - rx_ready = 1.
    - parity_err = par_bad & parity_en.
    - framing_err = (stop sample == 0).
  - If rx_ready = 1 and there is no read: overflow = 1; rx_byte and error flags are unchanged; the frame is dropped.
- read_rx_byte clears rx_ready and overflow the next cycle; rx_byte and the error flags hold.
- Load and read in the same cycle: the load wins (rx_ready stays 1, overflow not set).
- Latency: rx_ready rises 1 clk after the stop-bit sample tick.
- A config change (bit8, parity_en, odd_n_even) mid-frame is sampled live and is not required to produce a sensible frame; software changes config only when rx_idle = 1.
- A framing error with a low line does not block the receiver: IDLE restarts on the next tick seeing rx_s = 0, so a break is received as repeated 0x00 frames with framing_err = 1.
- Reset asserted mid-frame aborts it with no load.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit (start, data, parity, stop) is sampled at samp_cnt 7, 8 and 9.
  - The bit value is the 2-of-3 majority.
  - Decisions are taken at samp_cnt 9 (SP = 9), so stop-to-rx_ready latency grows by one tick.
  - False-start rejection uses the voted value.
- Undefined: single sample at samp_cnt 8; no vote registers are synthesised.

Test Plan:
- 8N1, byte 0xA5, ideal timing -> rx_byte = 0xA5, rx_ready = 1, parity_err = 0, framing_err = 0; read_rx_byte pulse -> rx_ready = 0 next clk.
- 7E1, data 0x41 with correct parity bit 0, then 0x41 with parity bit 1 -> first frame parity_err = 0, second frame parity_err = 1; rx_byte = 0x41 both times.
- rx low for 6 ticks then high -> FSM returns to IDLE, rx_ready stays 0. With UART_RX_MAJORITY_VOTE_EN, a single-tick low glitch at tick 8 inside bit 3 of 0xFF -> rx_byte = 0xFF.
- 8N1 0x3C with stop bit held low -> framing_err = 1, rx_byte = 0x3C; line back high, then 0x55 -> framing_err = 0.
- Two frames 0x11 then 0x22 with no read -> rx_byte = 0x11, overflow = 1; read_rx_byte -> overflow = 0, rx_ready = 0.
- Reset pulse mid-DATA of 0xF0, then a clean 0x0F -> no load from the aborted frame; rx_byte = 0x0F, rx_ready = 1.
